// File: rtl/mux_sel_arb_pkg.sv
// mux_sel_arb_pkg: shared constants for the N-way registered data selector.
//   MODE_FIXED / MODE_RR : values of the mode input.
//   sel_w()              : index width for a given channel count (min 1 bit).
package mux_sel_arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_sel_arb_if.sv
// mux_sel_arb_if: bus between channel sources / consumer and the selector.
//   in_data   CHANNELS*WIDTH  flattened channel data, ch i at [i*WIDTH +: WIDTH]
//   in_valid  CHANNELS        per-channel valid
//   in_ready  CHANNELS        per-channel grant (one-hot or zero)
//   mode                      0 = fixed select, 1 = round-robin
//   sel       SEL_W           fixed-mode channel index
//   out_data  WIDTH           registered selected data
//   out_chan  SEL_W           registered source channel index
//   out_valid / out_ready     output handshake
// master = sources/consumer side, slave = the selector.
interface mux_sel_arb_if
  import mux_sel_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = sel_w(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_sel_arb_rr_arbiter.sv
// mux_sel_arb_rr_arbiter: combinational round-robin pick.
//   req       CHANNELS  request vector
//   ptr       SEL_W     last granted index; search starts at ptr+1
//   enable    1         gates gnt_valid
//   gnt_valid 1         a request was found and enable=1
//   gnt_idx   SEL_W     chosen index (meaningful when a request exists)
module mux_sel_arb_rr_arbiter
  import mux_sel_arb_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SEL_W    = sel_w(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  input  logic                enable,
  output logic                gnt_valid,
  output logic [SEL_W-1:0]    gnt_idx
);

  int idx;

  // Walk from the farthest candidate (ptr itself) to the nearest (ptr+1);
  // the last hit wins, so ptr+1 has highest priority.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = CHANNELS; k >= 1; k--) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (req[idx]) begin
        gnt_valid = enable;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_sel_arb.sv
// mux_sel_arb: registered N-way data selector with fixed or round-robin pick.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  mux_sel_arb_if.slave (channel inputs, grants, registered output)
// One-cycle latency, full throughput while out_ready=1. A grant is only
// issued when the output register can load (empty or being drained).
module mux_sel_arb
  import mux_sel_arb_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux_sel_arb_if.slave  bus
);
  localparam int SEL_W = sel_w(CHANNELS);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] g;
  logic             rr_v;
  logic             fix_v;
  logic             load_en;
  logic             grant;

  assign load_en = !bus.out_valid || bus.out_ready;

  mux_sel_arb_rr_arbiter #(.CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_rr_arbiter (
    .req       (bus.in_valid),
    .ptr       (ptr),
    .enable    (load_en && !rst && (bus.mode == MODE_RR)),
    .gnt_valid (rr_v),
    .gnt_idx   (rr_idx)
  );

  // Fixed path: an out-of-range sel (non-power-of-2 CHANNELS) never grants.
  always_comb begin
    fix_v = 1'b0;
    if (int'(bus.sel) < CHANNELS) fix_v = bus.in_valid[bus.sel];
  end

  always_comb begin
    g     = (bus.mode == MODE_RR) ? rr_idx : bus.sel;
    grant = (bus.mode == MODE_RR) ? rr_v : (fix_v && load_en && !rst);
    bus.in_ready = '0;
    for (int i = 0; i < CHANNELS; i++)
      bus.in_ready[i] = grant && (int'(g) == i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_chan  <= '0;
      ptr           <= SEL_W'(CHANNELS - 1);
    end else if (grant) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= bus.in_data[int'(g)*WIDTH +: WIDTH];
      bus.out_chan  <= g;
      ptr           <= g;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule
